// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Optional feature macro: INST_FETCH_BYPASS_EN (see inst_fetch.sv).
package inst_fetch_pkg;

    localparam int                   CPU_WIDTH           = 32;
    localparam logic [CPU_WIDTH-1:0] INST_FETCH_RESET_PC = 32'h0000_0000;
    localparam int                   INST_FIFO_DEPTH     = 2;
    localparam logic [CPU_WIDTH-1:0] PC_STEP             = 32'd4;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] data;
    } fetch_entry_t;

    function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] addr);
        return {addr[CPU_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, EX redirect and decode handshake.
// master = fetch unit, slave = memory/pipeline environment.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [CPU_WIDTH-1:0] imem_req_addr;
    logic                 imem_rsp_valid;
    logic [CPU_WIDTH-1:0] imem_rsp_data;
    logic                 redirect_en;
    logic [CPU_WIDTH-1:0] redirect_pc;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [CPU_WIDTH-1:0] inst;
    logic [CPU_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_en, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_en, redirect_pc, inst_ready
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// inst_fifo: synchronous FIFO holding {pc, word} entries between memory and decode.
// DEPTH must be a power of two so the pointers wrap on their own.
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push-while-full is accepted then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, in-order imem requests, response FIFO, decode handshake, EX redirect.
// Optional macro INST_FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC   = INST_FETCH_RESET_PC,
    parameter int                   FIFO_DEPTH = INST_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CPU_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0] rsp_pc;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     drop_cnt;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [CNT_W:0]       occupancy;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 req_fire;
    logic                 rsp_keep;
    logic                 bypass_vld;
    fetch_entry_t         rsp_entry;
    fetch_entry_t         head;

    // Every request in flight owns a FIFO slot, so responses never need backpressure.
    assign occupancy          = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign bus.imem_req_valid = !rst && !bus.redirect_en && !fifo_full
                                && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_keep  = bus.imem_rsp_valid && !bus.redirect_en && (drop_cnt == '0);
    assign rsp_entry = '{pc: rsp_pc, data: bus.imem_rsp_data};

`ifdef INST_FETCH_BYPASS_EN
    assign bypass_vld = rsp_keep && fifo_empty;
`else
    assign bypass_vld = 1'b0;
`endif

    assign fifo_push = rsp_keep && !(bypass_vld && bus.inst_ready);
    assign fifo_pop  = !fifo_empty && bus.inst_ready && !bus.redirect_en;

    inst_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (bus.redirect_en),
        .wdata (rsp_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Decode sees a zero word whenever nothing is valid.
    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        bus.inst_pc    = rsp_pc;
        if (!fifo_empty) begin
            bus.inst_valid = 1'b1;
            bus.inst       = head.data;
            bus.inst_pc    = head.pc;
        end else if (bypass_vld) begin
            bus.inst_valid = 1'b1;
            bus.inst       = bus.imem_rsp_data;
            bus.inst_pc    = rsp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (bus.redirect_en) begin
                // Everything still outstanding is wrong-path; a response arriving now is dropped too.
                pc       <= align_pc(bus.redirect_pc);
                rsp_pc   <= align_pc(bus.redirect_pc);
                drop_cnt <= inflight - CNT_W'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + PC_STEP;
                if (bus.imem_rsp_valid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
                    else                rsp_pc   <= rsp_pc + PC_STEP;
                end
            end
        end
    end

endmodule
